// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Staged reset release for a PicoBlaze subsystem. It sits directly behind the
//   clock/reset controller: peripherals leave reset first, then the CPU. It also
//   provides a CPU-only watchdog reset and a software-requested full reset, and
//   it records the cause of the most recent reset.
//
// Ports
//   clk           in   system clock (buffered MMCM clock)
//   reset         in   synchronous active-high reset from the system controller
//   wdt_enable    in   watchdog enable, only looked at while running
//   wdt_kick      in   one-cycle watchdog restart strobe
//   sw_reset_req  in   one-cycle full-reset request
//   periph_reset  out  active-high peripheral reset
//   cpu_reset     out  active-high CPU reset
//   ready         out  high while the sequencer is running
//   reset_cause   out  00 system, 01 watchdog, 10 software
//
// Parameters
//   STAGE_DELAY  clock cycles spent in each reset stage (>= 1)
//   WDT_WIDTH    watchdog counter width
//   WDT_TIMEOUT  unkicked enabled cycles before expiry (>= 2, fits WDT_WIDTH)

module reset_sequencer #(
  parameter int unsigned STAGE_DELAY = 16,
  parameter int unsigned WDT_WIDTH   = 16,
  parameter int unsigned WDT_TIMEOUT = 16'hFFFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wdt_enable,
  input  logic       wdt_kick,
  input  logic       sw_reset_req,
  output logic       periph_reset,
  output logic       cpu_reset,
  output logic       ready,
  output logic [1:0] reset_cause
);

  localparam int unsigned CW = $clog2(STAGE_DELAY + 1);

  localparam logic [CW-1:0]        STAGE_LAST = CW'(STAGE_DELAY - 1);
  localparam logic [WDT_WIDTH-1:0] WDT_LAST   = WDT_WIDTH'(WDT_TIMEOUT - 1);

  localparam logic [1:0] CAUSE_SYSTEM   = 2'b00;
  localparam logic [1:0] CAUSE_WATCHDOG = 2'b01;
  localparam logic [1:0] CAUSE_SOFTWARE = 2'b10;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    PERIPH  = 2'd1,
    RUN     = 2'd2,
    CPU_RST = 2'd3
  } state_t;

  state_t                 state;
  logic [CW-1:0]          stage_cnt;
  logic [WDT_WIDTH-1:0]   wdt_cnt;

  logic stage_done;
  logic wdt_expire;

  assign stage_done = (stage_cnt == STAGE_LAST);
  // A kick on the terminal-count cycle suppresses expiry.
  assign wdt_expire = wdt_enable && !wdt_kick && (wdt_cnt == WDT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= HOLD;
      stage_cnt    <= '0;
      wdt_cnt      <= '0;
      periph_reset <= 1'b1;
      cpu_reset    <= 1'b1;
      ready        <= 1'b0;
      reset_cause  <= CAUSE_SYSTEM;
    end else begin
      case (state)
        HOLD: begin
          if (stage_done) begin
            state        <= PERIPH;
            stage_cnt    <= '0;
            periph_reset <= 1'b0;
          end else begin
            stage_cnt <= stage_cnt + CW'(1);
          end
        end

        PERIPH: begin
          if (stage_done) begin
            state     <= RUN;
            stage_cnt <= '0;
            cpu_reset <= 1'b0;
            ready     <= 1'b1;
          end else begin
            stage_cnt <= stage_cnt + CW'(1);
          end
        end

        RUN: begin
          // Software request outranks a simultaneous watchdog expiry.
          if (sw_reset_req) begin
            state        <= HOLD;
            stage_cnt    <= '0;
            wdt_cnt      <= '0;
            periph_reset <= 1'b1;
            cpu_reset    <= 1'b1;
            ready        <= 1'b0;
            reset_cause  <= CAUSE_SOFTWARE;
          end else if (wdt_expire) begin
            state       <= CPU_RST;
            stage_cnt   <= '0;
            wdt_cnt     <= '0;
            cpu_reset   <= 1'b1;
            ready       <= 1'b0;
            reset_cause <= CAUSE_WATCHDOG;
          end else if (!wdt_enable || wdt_kick) begin
            wdt_cnt <= '0;
          end else begin
            wdt_cnt <= wdt_cnt + WDT_WIDTH'(1);
          end
        end

        CPU_RST: begin
          if (stage_done) begin
            state     <= RUN;
            stage_cnt <= '0;
            cpu_reset <= 1'b0;
            ready     <= 1'b1;
          end else begin
            stage_cnt <= stage_cnt + CW'(1);
          end
        end

        default: begin
          state        <= HOLD;
          stage_cnt    <= '0;
          wdt_cnt      <= '0;
          periph_reset <= 1'b1;
          cpu_reset    <= 1'b1;
          ready        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer
//   Directed bench for reset_sequencer with STAGE_DELAY=4, WDT_TIMEOUT=10.
//   Inputs change 1 time unit after a rising edge; outputs are sampled there too,
//   so each sample shows the result of the edge just passed.

module tb_reset_sequencer;

  localparam int unsigned SD  = 4;
  localparam int unsigned WDT = 10;

  logic       clk;
  logic       reset;
  logic       wdt_enable;
  logic       wdt_kick;
  logic       sw_reset_req;
  logic       periph_reset;
  logic       cpu_reset;
  logic       ready;
  logic [1:0] reset_cause;

  int checks = 0;
  int errors = 0;

  reset_sequencer #(
    .STAGE_DELAY (SD),
    .WDT_WIDTH   (16),
    .WDT_TIMEOUT (WDT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wdt_enable   (wdt_enable),
    .wdt_kick     (wdt_kick),
    .sw_reset_req (sw_reset_req),
    .periph_reset (periph_reset),
    .cpu_reset    (cpu_reset),
    .ready        (ready),
    .reset_cause  (reset_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Power-up: 5 cycles of reset, then staged release at edges 4 and 8.
  task automatic test_reset();
    logic ep, ec, er;
    reset = 1'b1; wdt_enable = 1'b0; wdt_kick = 1'b0; sw_reset_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (periph_reset !== 1'b1 || cpu_reset !== 1'b1 || ready !== 1'b0 || reset_cause !== 2'b00) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: got p=%b c=%b r=%b cause=%b, want p=1 c=1 r=0 cause=00",
                 i, periph_reset, cpu_reset, ready, reset_cause);
      end
    end
    reset = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      ep = (e < 4); ec = (e < 8); er = (e >= 8);
      checks++;
      if (periph_reset !== ep || cpu_reset !== ec || ready !== er || reset_cause !== 2'b00) begin
        errors++;
        $display("FAIL powerup_release edge %0d: got p=%b c=%b r=%b cause=%b, want p=%b c=%b r=%b cause=00",
                 e, periph_reset, cpu_reset, ready, reset_cause, ep, ec, er);
      end
    end
    $display("test_reset: power-up release done");
  endtask

  // Enabled, never kicked: expiry on the 10th RUN cycle, CPU held 4 cycles.
  task automatic test_watchdog();
    logic ec;
    wdt_enable = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      ec = (i == 10);
      checks++;
      if (cpu_reset !== ec || ready !== !ec || periph_reset !== 1'b0 ||
          (ec && reset_cause !== 2'b01)) begin
        errors++;
        $display("FAIL wdt_expiry cycle %0d: got p=%b c=%b r=%b cause=%b, want p=0 c=%b r=%b",
                 i, periph_reset, cpu_reset, ready, reset_cause, ec, !ec);
      end
    end
    for (int i = 1; i <= 4; i++) begin
      tick();
      ec = (i < 4);
      checks++;
      if (cpu_reset !== ec || ready !== !ec || periph_reset !== 1'b0 || reset_cause !== 2'b01) begin
        errors++;
        $display("FAIL wdt_cpu_rst cycle %0d: got p=%b c=%b r=%b cause=%b, want p=0 c=%b r=%b cause=01",
                 i, periph_reset, cpu_reset, ready, reset_cause, ec, !ec);
      end
    end
    wdt_enable = 1'b0;
    $display("test_watchdog: expiry and CPU-only reset done");
  endtask

  // Kicks every 9 cycles never expire; a kick on the terminal cycle restarts count.
  task automatic test_kick_boundary();
    logic ec;
    wdt_enable = 1'b1;
    for (int i = 0; i < 200; i++) begin
      wdt_kick = ((i % 9) == 8);
      tick();
      checks++;
      if (ready !== 1'b1 || cpu_reset !== 1'b0) begin
        errors++;
        $display("FAIL kick_every_9 cycle %0d: got c=%b r=%b, want c=0 r=1", i, cpu_reset, ready);
      end
    end
    wdt_kick = 1'b0;
    wdt_enable = 1'b0;
    tick();
    wdt_enable = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      wdt_kick = (i == 10);
      tick();
      ec = (i == 20);
      checks++;
      if (cpu_reset !== ec || ready !== !ec) begin
        errors++;
        $display("FAIL kick_terminal cycle %0d: got c=%b r=%b, want c=%b r=%b",
                 i, cpu_reset, ready, ec, !ec);
      end
    end
    wdt_kick = 1'b0;
    wdt_enable = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (ready !== 1'b1 || cpu_reset !== 1'b0) begin
      errors++;
      $display("FAIL kick_terminal_return: got c=%b r=%b, want c=0 r=1", cpu_reset, ready);
    end
    $display("test_kick_boundary: kick spacing and terminal kick done");
  endtask

  // Software request in RUN: full staged reset, cause 10.
  task automatic test_sw_reset();
    logic ep, ec, er;
    sw_reset_req = 1'b1;
    tick();
    sw_reset_req = 1'b0;
    checks++;
    if (periph_reset !== 1'b1 || cpu_reset !== 1'b1 || ready !== 1'b0 || reset_cause !== 2'b10) begin
      errors++;
      $display("FAIL sw_reset_assert: got p=%b c=%b r=%b cause=%b, want p=1 c=1 r=0 cause=10",
               periph_reset, cpu_reset, ready, reset_cause);
    end
    for (int e = 1; e <= 10; e++) begin
      tick();
      ep = (e < 4); ec = (e < 8); er = (e >= 8);
      checks++;
      if (periph_reset !== ep || cpu_reset !== ec || ready !== er || reset_cause !== 2'b10) begin
        errors++;
        $display("FAIL sw_reset_release edge %0d: got p=%b c=%b r=%b cause=%b, want p=%b c=%b r=%b cause=10",
                 e, periph_reset, cpu_reset, ready, reset_cause, ep, ec, er);
      end
    end
    $display("test_sw_reset: software reset done");
  endtask

  // System reset during CPU_RST (stage count 2) wins and restarts from HOLD.
  task automatic test_mid_reset();
    logic ep, ec, er;
    wdt_enable = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    wdt_enable = 1'b0;
    tick();
    tick();
    checks++;
    if (cpu_reset !== 1'b1 || periph_reset !== 1'b0 || reset_cause !== 2'b01) begin
      errors++;
      $display("FAIL mid_reset_pre: got p=%b c=%b cause=%b, want p=0 c=1 cause=01",
               periph_reset, cpu_reset, reset_cause);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (periph_reset !== 1'b1 || cpu_reset !== 1'b1 || ready !== 1'b0 || reset_cause !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset_assert: got p=%b c=%b r=%b cause=%b, want p=1 c=1 r=0 cause=00",
               periph_reset, cpu_reset, ready, reset_cause);
    end
    reset = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      ep = (e < 4); ec = (e < 8); er = (e >= 8);
      checks++;
      if (periph_reset !== ep || cpu_reset !== ec || ready !== er || reset_cause !== 2'b00) begin
        errors++;
        $display("FAIL mid_reset_release edge %0d: got p=%b c=%b r=%b cause=%b, want p=%b c=%b r=%b cause=00",
                 e, periph_reset, cpu_reset, ready, reset_cause, ep, ec, er);
      end
    end
    $display("test_mid_reset: reset during CPU_RST done");
  endtask

  // Software request on the expiry cycle: software wins.
  task automatic test_sw_wdt_collision();
    logic ep, ec, er;
    wdt_enable = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    sw_reset_req = 1'b1;
    tick();
    sw_reset_req = 1'b0;
    wdt_enable = 1'b0;
    checks++;
    if (periph_reset !== 1'b1 || cpu_reset !== 1'b1 || ready !== 1'b0 || reset_cause !== 2'b10) begin
      errors++;
      $display("FAIL collision_assert: got p=%b c=%b r=%b cause=%b, want p=1 c=1 r=0 cause=10",
               periph_reset, cpu_reset, ready, reset_cause);
    end
    for (int e = 1; e <= 10; e++) begin
      tick();
      ep = (e < 4); ec = (e < 8); er = (e >= 8);
      checks++;
      if (periph_reset !== ep || cpu_reset !== ec || ready !== er || reset_cause !== 2'b10) begin
        errors++;
        $display("FAIL collision_release edge %0d: got p=%b c=%b r=%b cause=%b, want p=%b c=%b r=%b cause=10",
                 e, periph_reset, cpu_reset, ready, reset_cause, ep, ec, er);
      end
    end
    $display("test_sw_wdt_collision: software beats watchdog done");
  endtask

  // Strobes during HOLD/PERIPH must not disturb release timing or cause.
  task automatic test_ignored_outside_run();
    logic ep, ec, er;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      sw_reset_req = (e == 2 || e == 6);
      wdt_kick     = (e == 3 || e == 7);
      wdt_enable   = (e == 5);
      tick();
      ep = (e < 4); ec = (e < 8); er = (e >= 8);
      checks++;
      if (periph_reset !== ep || cpu_reset !== ec || ready !== er || reset_cause !== 2'b00) begin
        errors++;
        $display("FAIL ignored_release edge %0d: got p=%b c=%b r=%b cause=%b, want p=%b c=%b r=%b cause=00",
                 e, periph_reset, cpu_reset, ready, reset_cause, ep, ec, er);
      end
    end
    sw_reset_req = 1'b0;
    wdt_kick = 1'b0;
    wdt_enable = 1'b0;
    $display("test_ignored_outside_run: strobes during staging ignored");
  endtask

  // Watchdog disabled for 1000 cycles: no reset at all.
  task automatic test_wdt_disabled();
    wdt_enable = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      checks++;
      if (ready !== 1'b1 || cpu_reset !== 1'b0 || periph_reset !== 1'b0) begin
        errors++;
        $display("FAIL wdt_disabled cycle %0d: got p=%b c=%b r=%b, want p=0 c=0 r=1",
                 i, periph_reset, cpu_reset, ready);
      end
    end
    $display("test_wdt_disabled: 1000 cycles without reset");
  endtask

  initial begin
    reset = 1'b1;
    wdt_enable = 1'b0;
    wdt_kick = 1'b0;
    sw_reset_req = 1'b0;
    test_reset();
    test_watchdog();
    test_kick_boundary();
    test_sw_reset();
    test_mid_reset();
    test_sw_wdt_collision();
    test_ignored_outside_run();
    test_wdt_disabled();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Sits directly downstream of the clock/reset system controller. Its clock input is the controller's buffered MMCM clock; its reset input is the controller's combined reset output (MMCM not locked, or reset counter running).
- Releases resets in stages: peripherals first, then the PicoBlaze CPU.
- Provides a CPU-only watchdog reset and a software full-reset request.
- Reports the cause of the last reset.

Parameters:
- STAGE_DELAY, 16: clock cycles per reset stage. Must be >= 1. Counter width is $clog2(STAGE_DELAY+1).
- WDT_WIDTH, 16: watchdog counter width.
- WDT_TIMEOUT, 16'hFFFF: cycles without a kick before watchdog expiry. Must be >= 2 and must fit in WDT_WIDTH.

Ports:
- clk  input  1  system clock from the system controller.
- reset  input  1  synchronous, active-high reset from the system controller.
- wdt_enable  input  1  watchdog enable. Sampled only in RUN.
- wdt_kick  input  1  one-cycle watchdog restart strobe from the CPU port logic.
- sw_reset_req  input  1  one-cycle strobe requesting a full reset.
- periph_reset  output  1  active-high reset to peripherals.
- cpu_reset  output  1  active-high reset to the PicoBlaze.
- ready  output  1  high while in RUN.
- reset_cause  output  2  cause of last reset: 00 system, 01 watchdog, 10 software. 11 is never produced.

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high.
  - All outputs are registered and change on the same clk edge as the state.
- Outputs while reset=1:
  - state=HOLD, stage counter=0, watchdog counter=0.
  - periph_reset=1, cpu_reset=1, ready=0, reset_cause=00.
  - reset overrides everything. Asserting it in any state, including mid-stage, gives these values on the next edge.
- States:
  - HOLD: periph_reset=1, cpu_reset=1, ready=0. Stage counter increments each cycle. When counter==STAGE_DELAY-1, go to PERIPH and clear the counter.
  - PERIPH: periph_reset=0, cpu_reset=1, ready=0. Same counting rule, then go to RUN.
  - RUN: periph_reset=0, cpu_reset=0, ready=1.
  - CPU_RST: periph_reset=0, cpu_reset=1, ready=0. Same counting rule, then go to RUN.
- Release timing: edge 1 is the first edge with reset=0.
  - periph_reset falls on edge STAGE_DELAY.
  - cpu_reset falls and ready rises on edge 2*STAGE_DELAY.
- Watchdog counter (RUN only):
  - Clears when wdt_enable=0 or wdt_kick=1; otherwise increments.
  - Expiry: wdt_enable=1, wdt_kick=0 and counter==WDT_TIMEOUT-1. Go to CPU_RST and set reset_cause=01.
  - Expiry therefore occurs on the WDT_TIMEOUT-th consecutive unkicked enabled cycle.
  - If a kick and the terminal count occur in the same cycle, the kick wins: no expiry, counter cleared.
  - Counter is cleared on every exit from RUN and held at 0 outside RUN.
- Software reset:
  - sw_reset_req in RUN goes to HOLD, sets reset_cause=10, clears the stage counter.
  - Both resets reassert on the next edge and release in stages as above.
  - sw_reset_req in the same cycle as watchdog expiry: software wins (HOLD, cause 10).
- Outside RUN, sw_reset_req and wdt_kick are ignored.
- reset_cause holds its value until the next reset event.

Test Plan (STAGE_DELAY=4, WDT_TIMEOUT=10):
- Power-up: hold reset 5 cycles, then release. periph_reset falls after edge 4; cpu_reset falls and ready rises after edge 8; reset_cause=00.
- Watchdog expiry: wdt_enable=1, no kicks. On the 10th RUN cycle, cpu_reset=1 and ready=0 for 4 cycles; periph_reset stays 0; reset_cause=01; then RUN again.
- Kick boundary: kick every 9 cycles for 200 cycles gives no expiry. A kick exactly on the terminal-count cycle gives no expiry and the counter returns to 0.
- Software reset: sw_reset_req pulse in RUN makes both resets 1 on the next edge, staged release at 4/8 edges, reset_cause=10. sw_reset_req coincident with expiry gives reset_cause=10 and the full HOLD sequence.
- Mid-operation reset: assert reset during CPU_RST (counter=2). Next edge gives HOLD, periph_reset=1, reset_cause=00; full 4/8 release after deassertion.
- Watchdog disabled: wdt_enable=0 in RUN for 1000 cycles gives no reset. sw_reset_req and wdt_kick pulses during HOLD/PERIPH are ignored, with release timing unchanged.
